// File: rtl/branch_resolver_if.sv
// rtl/branch_resolver_if.sv - branch result / ROB head / fetch redirect bundle for branch_resolver
interface branch_resolver_if #(
    parameter int IDX_W = 4,
    parameter int PC_W  = 16,
    parameter int CNT_W = 8
);
    logic             br_valid;
    logic [IDX_W-1:0] br_rob_index;
    logic [PC_W-1:0]  br_target;
    logic             br_taken;
    logic             alloc_valid;
    logic [IDX_W-1:0] alloc_index;
    logic             head_valid;
    logic             head_is_branch;
    logic [IDX_W-1:0] head_index;
    logic             fetch_ready;
    logic             commit_ready;
    logic             flush;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output br_valid, br_rob_index, br_target, br_taken,
        output alloc_valid, alloc_index,
        output head_valid, head_is_branch, head_index, fetch_ready,
        input  commit_ready, flush, redirect_valid, redirect_pc, flush_count
    );

    modport slave (
        input  br_valid, br_rob_index, br_target, br_taken,
        input  alloc_valid, alloc_index,
        input  head_valid, head_is_branch, head_index, fetch_ready,
        output commit_ready, flush, redirect_valid, redirect_pc, flush_count
    );
endinterface

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - per-ROB branch resolution table, head retire and flush/redirect FSM
module branch_resolver #(
    parameter int ROB_SIZE = 16,
    parameter int IDX_W    = 4,
    parameter int PC_W     = 16,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    branch_resolver_if.slave   bus
);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [ROB_SIZE-1:0] resolved_q, resolved_d;
    logic [ROB_SIZE-1:0] taken_q;
    logic [PC_W-1:0]     target_q [ROB_SIZE];
    logic [PC_W-1:0]     redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]    flush_count_q, flush_count_d;

    logic hit;
    logic br_wr;
    logic commit_ready;
    logic flush;
    logic redirect_valid;

    // Head decision looks only at registered table state; no same-cycle bypass of br data.
    assign hit = bus.head_valid & bus.head_is_branch & resolved_q[bus.head_index];

    always_comb begin
        state_d        = state_q;
        resolved_d     = resolved_q;
        redirect_pc_d  = redirect_pc_q;
        flush_count_d  = flush_count_q;
        commit_ready   = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        br_wr          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                br_wr = bus.br_valid;
                if (hit) begin
                    if (!taken_q[bus.head_index]) begin
                        commit_ready                = 1'b1;
                        resolved_d[bus.head_index]  = 1'b0;
                    end else begin
                        redirect_pc_d = target_q[bus.head_index];
                        state_d       = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                flush          = 1'b1;
                commit_ready   = 1'b1;
                redirect_valid = 1'b1;
                flush_count_d  = flush_count_q + 1'b1;
                state_d        = bus.fetch_ready ? ST_IDLE : ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                if (bus.fetch_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Later assignments take priority: flush clear > alloc clear > branch write.
        if (br_wr) begin
            resolved_d[bus.br_rob_index] = 1'b1;
        end
        if (bus.alloc_valid) begin
            resolved_d[bus.alloc_index] = 1'b0;
        end
        if (state_q == ST_FLUSH) begin
            resolved_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            resolved_q    <= '0;
            redirect_pc_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            resolved_q    <= resolved_d;
            redirect_pc_q <= redirect_pc_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Payload is only meaningful while resolved is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (br_wr) begin
            taken_q[bus.br_rob_index]  <= bus.br_taken;
            target_q[bus.br_rob_index] <= bus.br_target;
        end
    end

    assign bus.commit_ready   = commit_ready;
    assign bus.flush          = flush;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush_count    = flush_count_q;
endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - table-driven directed checks for branch_resolver
module tb_branch_resolver;
    localparam int IDX_W = 4;
    localparam int PC_W  = 16;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_resolver_if #(.IDX_W(IDX_W), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    branch_resolver #(.ROB_SIZE(16), .IDX_W(IDX_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic             rst;
        logic             bv;
        logic [IDX_W-1:0] bidx;
        logic [PC_W-1:0]  btgt;
        logic             btk;
        logic             av;
        logic [IDX_W-1:0] aidx;
        logic             hv;
        logic             hb;
        logic [IDX_W-1:0] hidx;
        logic             fr;
        logic             ec;
        logic             ef;
        logic             erv;
        logic [PC_W-1:0]  erpc;
        logic [CNT_W-1:0] ecnt;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic rst, input logic bv, input int bidx, input int btgt,
                                input logic btk, input logic av, input int aidx, input logic hv,
                                input logic hb, input int hidx, input logic fr, input logic ec,
                                input logic ef, input logic erv, input int erpc, input int ecnt);
        vec_t v;
        v.rst = rst; v.bv = bv; v.bidx = bidx[IDX_W-1:0]; v.btgt = btgt[PC_W-1:0]; v.btk = btk;
        v.av = av; v.aidx = aidx[IDX_W-1:0]; v.hv = hv; v.hb = hb; v.hidx = hidx[IDX_W-1:0];
        v.fr = fr; v.ec = ec; v.ef = ef; v.erv = erv; v.erpc = erpc[PC_W-1:0];
        v.ecnt = ecnt[CNT_W-1:0];
        return v;
    endfunction

    // Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        reset              = v.rst;
        bus.br_valid       = v.bv;
        bus.br_rob_index   = v.bidx;
        bus.br_target      = v.btgt;
        bus.br_taken       = v.btk;
        bus.alloc_valid    = v.av;
        bus.alloc_index    = v.aidx;
        bus.head_valid     = v.hv;
        bus.head_is_branch = v.hb;
        bus.head_index     = v.hidx;
        bus.fetch_ready    = v.fr;
        #4;
    endtask

    task automatic check(input int row, input vec_t v);
        tests++;
        if (bus.commit_ready !== v.ec || bus.flush !== v.ef || bus.redirect_valid !== v.erv ||
            bus.redirect_pc !== v.erpc || bus.flush_count !== v.ecnt) begin
            fails++;
            $display("FAIL row%0d: got commit=%b flush=%b rv=%b pc=%h cnt=%0d, want commit=%b flush=%b rv=%b pc=%h cnt=%0d",
                     row, bus.commit_ready, bus.flush, bus.redirect_valid, bus.redirect_pc,
                     bus.flush_count, v.ec, v.ef, v.erv, v.erpc, v.ecnt);
        end
    endtask

    initial begin
        int pulses;
        vec_t v;
        reset = 1'b1;
        bus.br_valid = 0; bus.br_rob_index = '0; bus.br_target = '0; bus.br_taken = 0;
        bus.alloc_valid = 0; bus.alloc_index = '0; bus.head_valid = 0; bus.head_is_branch = 0;
        bus.head_index = '0; bus.fetch_ready = 0;
        repeat (2) @(posedge clk);

        //               rst bv bidx btgt    tk av ai hv hb hi fr   ec ef rv rpc     cnt
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,      0)); // reset state
        vecs.push_back(mk(0, 1, 3,   'h0040, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,      0));
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 3, 0,   1, 0, 0, 0,      0)); // not-taken retires
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 3, 0,   0, 0, 0, 0,      0)); // retired entry cleared
        vecs.push_back(mk(0, 1, 6,   'h0066, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0,      0));
        vecs.push_back(mk(0, 1, 5,   'h1234, 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0,      0));
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 5, 1,   0, 0, 0, 0,      0)); // taken decision
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 5, 1,   1, 1, 1, 'h1234, 0)); // FLUSH
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 6, 1,   0, 0, 0, 'h1234, 1)); // table cleared
        vecs.push_back(mk(0, 1, 2,   'h0ABC, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 'h1234, 1));
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 2, 0,   0, 0, 0, 'h1234, 1));
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 2, 0,   1, 1, 1, 'h0ABC, 1)); // FLUSH, fetch stalls
        vecs.push_back(mk(0, 1, 7,   'h0077, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 'h0ABC, 2)); // br ignored
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 'h0ABC, 2));
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 'h0ABC, 2)); // transfer
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 7, 1,   0, 0, 0, 'h0ABC, 2)); // idx7 unresolved
        vecs.push_back(mk(0, 1, 9,   'h0099, 0, 1, 9, 0, 0, 0, 1,   0, 0, 0, 'h0ABC, 2)); // alloc vs br
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 9, 1,   0, 0, 0, 'h0ABC, 2));
        vecs.push_back(mk(0, 1, 9,   'h0099, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 'h0ABC, 2));
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 9, 1,   1, 0, 0, 'h0ABC, 2));
        vecs.push_back(mk(0, 1, 15,  'h00FF, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 'h0ABC, 2));
        vecs.push_back(mk(0, 1, 0,   'h0100, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 'h0ABC, 2));
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 15, 1,  1, 0, 0, 'h0ABC, 2)); // wrap, back-to-back
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 0, 1,   1, 0, 0, 'h0ABC, 2));
        vecs.push_back(mk(0, 1, 4,   'h0444, 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 'h0ABC, 2));
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 0, 4, 1,   0, 0, 0, 'h0ABC, 2)); // not a branch
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 0, 1, 4, 1,   0, 0, 0, 'h0ABC, 2)); // head invalid
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 4, 1,   0, 0, 0, 'h0ABC, 2));
        vecs.push_back(mk(0, 1, 8,   'h0088, 0, 0, 0, 1, 1, 4, 1,   1, 1, 1, 'h0444, 2)); // FLUSH, br ignored
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 8, 1,   0, 0, 0, 'h0444, 3));
        vecs.push_back(mk(0, 1, 1,   'h0111, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 'h0444, 3));
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 1, 0,   0, 0, 0, 'h0444, 3));
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 1, 0,   1, 1, 1, 'h0111, 3));
        vecs.push_back(mk(1, 0, 0,   0,      0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 'h0111, 4)); // reset in REDIRECT
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,      0));
        vecs.push_back(mk(0, 0, 0,   0,      0, 0, 0, 1, 1, 1, 0,   0, 0, 0, 0,      0)); // table cleared by reset

        foreach (vecs[i]) begin
            drive(vecs[i]);
            check(i, vecs[i]);
        end

        // 256 taken-branch flushes: the counter must read 255 before the last one and wrap to 0 after it.
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            drive(mk(0, 1, i % 16, i, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            if (i == 255) begin
                tests++;
                if (bus.flush_count !== 8'd255) begin
                    fails++;
                    $display("FAIL cnt_before_wrap: got %0d, want 255", bus.flush_count);
                end
            end
            drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, i % 16, 1, 0, 0, 0, 0, 0));
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            if (bus.flush === 1'b1) pulses++;
        end
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 255, 0);
        drive(v);
        check(1000, v);
        tests++;
        if (pulses != 256) begin
            fails++;
            $display("FAIL flush_pulses: got %0d, want 256", pulses);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
